// File: rtl/mux_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared widths and FSM state encoding for the 4:1 mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;
    localparam int SEL_W = 2;
    localparam int N_REQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux4_sel.sv
// ============================================================================
// Module      : mux4_sel
// Description : Combinational DATA_W-wide 4:1 select mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_sel
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = x0;
        case (sel)
            2'd0:    y = x0;
            2'd1:    y = x1;
            2'd2:    y = x2;
            2'd3:    y = x3;
            default: y = x0;
        endcase
    end

endmodule : mux4_sel

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter owning the select of a 4:1 mux, with a
//               bounded hold counter per ownership.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] m,
    output logic              m_valid
);

    localparam int              CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(HOLD_MAX - 1);

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
    function automatic logic [SEL_W:0] next_owner(
        input logic [N_REQ-1:0] req_v,
        input logic [SEL_W-1:0] start
    );
        logic [SEL_W:0]   result;
        logic [SEL_W-1:0] idx;
        result = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req_v[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    logic [0:0]        r_state;
    logic [N_REQ-1:0]  r_gnt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    logic [0:0]        w_state_nxt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [N_REQ-1:0]  w_scan_req;
    logic [SEL_W-1:0]  w_scan_start;
    logic [SEL_W:0]    w_pick;
    logic              w_take;
    logic [DATA_W-1:0] w_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= |w_gnt_nxt;
        end
    end

    // While granted, the owner is masked out and scanned last (start at owner+1).
    assign w_scan_req   = (r_state == ST_IDLE) ? req : (req & ~r_gnt);
    assign w_scan_start = (r_state == ST_IDLE) ? r_ptr : (r_sel + SEL_W'(1));
    assign w_pick       = next_owner(w_scan_req, w_scan_start);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take = w_pick[SEL_W];
            end
            ST_GRANT: begin
                if (!req[r_sel]) begin
                    w_take = w_pick[SEL_W];
                    if (!w_pick[SEL_W]) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if ((r_cnt == c_cnt_max) && w_pick[SEL_W]) begin
                    w_take = 1'b1;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_take) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = N_REQ'(1) << w_pick[SEL_W-1:0];
            w_sel_nxt   = w_pick[SEL_W-1:0];
            w_ptr_nxt   = w_pick[SEL_W-1:0] + SEL_W'(1);
            w_cnt_nxt   = '0;
        end
    end

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_mux (
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .sel (r_sel),
        .y   (w_y)
    );

    always_comb begin
        gnt     = r_gnt;
        sel     = r_sel;
        m_valid = r_valid;
        m       = r_valid ? w_y : '0;
    end

endmodule : mux_rr_arbiter

`default_nettype wire
